// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, full/empty, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read port; registered read port otherwise.
module sync_fifo_flags #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o
);
  localparam int CW = PTR_WIDTH + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic wr_err_q, wr_err_d, rd_err_q, rd_err_d, wr_acc, rd_acc;
  assign empty_o        = count_q == '0;
  assign full_o         = count_q == CW'(DEPTH);
  assign almost_full_o  = count_q >= CW'(AF_THRESH);
  assign almost_empty_o = count_q <= CW'(AE_THRESH);
  assign count_o        = count_q;
  assign wr_error_o     = wr_err_q;
  assign rd_error_o     = rd_err_q;
  // A read on a full FIFO frees the slot the simultaneous write lands in.
  always_comb begin
    rd_acc   = rd_en_i & ~empty_o;
    wr_acc   = wr_en_i & (~full_o | rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    wr_err_d = wr_en_i & ~wr_acc;
    rd_err_d = rd_en_i & ~rd_acc;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end
  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wdata_i;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign rdata_o = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
`else
  logic [WIDTH-1:0] rdata_q, rdata_d;
  assign rdata_d = rd_acc ? mem_q[rd_ptr_q[PTR_WIDTH-1:0]] : rdata_q;
  assign rdata_o = rdata_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
`endif
endmodule
